// File: rtl/game_pkg.sv
// game_pkg: symbols, seven-segment glyphs and memory geometry shared by the
// pattern writer, gameplay and the display path.
package game_pkg;

    localparam int          GAME_DEPTH        = 50;
    localparam int          GAME_BANKS        = 4;
    localparam int          GAME_ADDR_W       = 8;
    localparam int          GAME_DATA_W       = 28;
    localparam logic [15:0] GAME_DEFAULT_SEED = 16'hACE1;

    // Button symbols; SYM_NONE marks "no previous symbol" at a bank start
    typedef enum logic [2:0] {
        SYM_UP   = 3'd0,
        SYM_DOWN = 3'd1,
        SYM_LEFT = 3'd2,
        SYM_RITE = 3'd3,
        SYM_MID  = 3'd4,
        SYM_NONE = 3'd7
    } sym_t;

    // Pattern writer sequencing states
    typedef enum logic [1:0] {
        PW_IDLE  = 2'd0,
        PW_GEN   = 2'd1,
        PW_WRITE = 2'd2,
        PW_DONE  = 2'd3
    } pw_state_t;

    // Four digits of seven active-low segments (gfedcba per digit)
    localparam logic [GAME_DATA_W-1:0] GLYPH_UP    = 28'b1000001000110011111111111111;
    localparam logic [GAME_DATA_W-1:0] GLYPH_DOWN  = 28'b1000000100000010101011001000;
    localparam logic [GAME_DATA_W-1:0] GLYPH_LEFT  = 28'b1000111000011000011100000111;
    localparam logic [GAME_DATA_W-1:0] GLYPH_RITE  = 28'b1001100111100100001110000110;
    localparam logic [GAME_DATA_W-1:0] GLYPH_MID   = 28'b1101010111100110000001111111;
    localparam logic [GAME_DATA_W-1:0] GLYPH_GOOD  = 28'b1000010100000010000000100001;
    localparam logic [GAME_DATA_W-1:0] GLYPH_LOSE  = 28'b1000111100000000100100000110;
    localparam logic [GAME_DATA_W-1:0] GLYPH_BLANK = 28'b1111111111111111111111111111;

    // Map a button symbol to the glyph stored in pattern memory
    function automatic logic [GAME_DATA_W-1:0] glyph_of(input sym_t sym);
        logic [GAME_DATA_W-1:0] glyph;
        case (sym)
            SYM_UP:   glyph = GLYPH_UP;
            SYM_DOWN: glyph = GLYPH_DOWN;
            SYM_LEFT: glyph = GLYPH_LEFT;
            SYM_RITE: glyph = GLYPH_RITE;
            SYM_MID:  glyph = GLYPH_MID;
            default:  glyph = GLYPH_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/pattern_writer_if.sv
// pattern_writer_if: control handshake from the menu FSM plus the block
// memory write port driven by the pattern writer.
interface pattern_writer_if
    import game_pkg::*;
#(
    parameter int ADDR_W = GAME_ADDR_W,
    parameter int DATA_W = GAME_DATA_W
);
    logic              start;
    logic              seed_load;
    logic [15:0]       seed;
    logic              busy;
    logic              done;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [7:0]        fill_count;

    // The writer side: takes commands, drives status and the memory port
    modport master (
        input  start, seed_load, seed,
        output busy, done, wea, addra, dina, fill_count
    );

    // The menu / memory side
    modport slave (
        output start, seed_load, seed,
        input  busy, done, wea, addra, dina, fill_count
    );
endinterface

// File: rtl/pattern_writer_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, shifting left).
// value_next is the value a shift would produce, so a caller can act on the
// post-shift bits in the same cycle it enables the shift.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] DEFAULT_SEED = GAME_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value,
    output logic [15:0] value_next
);

    if (DEFAULT_SEED == 16'h0000) begin : g_seed_check
        $error("lfsr16: DEFAULT_SEED must be non-zero");
    end

    assign value_next = {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};

    // Seed load wins over shifting; a zero seed would lock the register up
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
        end else if (enable) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/pattern_writer.sv
// pattern_writer: at the start of each game, writes BANKS x DEPTH random
// button glyphs into the pattern block memory, bank after bank, one write
// every GEN/WRITE pair. Rejected LFSR draws simply spend extra GEN cycles.
module pattern_writer
    import game_pkg::*;
#(
    parameter int          DEPTH        = GAME_DEPTH,
    parameter int          BANKS        = GAME_BANKS,
    parameter int          ADDR_W       = GAME_ADDR_W,
    parameter int          DATA_W       = GAME_DATA_W,
    parameter logic [15:0] DEFAULT_SEED = GAME_DEFAULT_SEED,
    parameter bit          NO_REPEAT    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    pattern_writer_if.master bus
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    if (BANKS * DEPTH - 1 >= (1 << ADDR_W)) begin : g_addr_check
        $error("pattern_writer: BANKS*DEPTH-1 does not fit in ADDR_W bits");
    end
    if (DATA_W != GAME_DATA_W) begin : g_data_check
        $error("pattern_writer: DATA_W must match the glyph width");
    end
    if (BANKS * DEPTH > 255) begin : g_count_check
        $error("pattern_writer: fill_count is 8 bits wide");
    end

    pw_state_t         state;
    pw_state_t         state_next;
    logic [IDX_W-1:0]  idx;
    logic [BANK_W-1:0] bank;
    sym_t              prev_sym;
    sym_t              sym_q;
    sym_t              cand_sym;
    logic              cand_ok;
    logic              last_idx;
    logic              last_bank;
    logic              lfsr_enable;
    logic              lfsr_load;
    logic [15:0]       lfsr_now;
    logic [15:0]       lfsr_next;
    logic              lfsr_unused;
    logic [ADDR_W-1:0] addr_calc;
    logic [ADDR_W-1:0] addra_q;
    logic [DATA_W-1:0] dina_q;
    logic [7:0]        fill_count_q;
    logic              wr_pulse;
    logic              busy_flag;
    logic              done_pulse;

    lfsr16 #(
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .enable     (lfsr_enable),
        .load       (lfsr_load),
        .seed       (bus.seed),
        .value      (lfsr_now),
        .value_next (lfsr_next)
    );

    // Only the low three bits of a fresh shift choose a symbol; the rest of
    // the LFSR state matters solely for the following shifts.
    assign lfsr_unused = ^{lfsr_now, lfsr_next[15:3]};

    assign last_idx  = (idx == IDX_W'(DEPTH - 1));
    assign last_bank = (bank == BANK_W'(BANKS - 1));
    assign addr_calc = ADDR_W'(bank) * ADDR_W'(DEPTH) + ADDR_W'(idx);

    // Judge the symbol this GEN shift produces: out-of-range codes and,
    // inside a bank, a repeat of the previous symbol are thrown away
    always_comb begin
        cand_sym = SYM_NONE;
        cand_ok  = 1'b0;
        if (lfsr_next[2:0] <= 3'd4) begin
            cand_sym = sym_t'(lfsr_next[2:0]);
            cand_ok  = 1'b1;
            if (NO_REPEAT && (idx != '0) && (cand_sym == prev_sym)) begin
                cand_ok = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PW_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the state-derived strobes
    always_comb begin
        state_next  = state;
        lfsr_enable = 1'b0;
        lfsr_load   = 1'b0;
        wr_pulse    = 1'b0;
        busy_flag   = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            PW_IDLE: begin
                lfsr_load = bus.seed_load;
                if (bus.start) begin
                    state_next = PW_GEN;
                end
            end
            PW_GEN: begin
                busy_flag   = 1'b1;
                lfsr_enable = 1'b1;
                if (cand_ok) begin
                    state_next = PW_WRITE;
                end
            end
            PW_WRITE: begin
                busy_flag = 1'b1;
                wr_pulse  = 1'b1;
                if (last_idx && last_bank) begin
                    state_next = PW_DONE;
                end else begin
                    state_next = PW_GEN;
                end
            end
            PW_DONE: begin
                done_pulse = 1'b1;
                state_next = PW_IDLE;
            end
            default: begin
                state_next = PW_IDLE;
            end
        endcase
    end

    // Fill position, write port registers and the completed-write count
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            bank         <= '0;
            prev_sym     <= SYM_NONE;
            sym_q        <= SYM_NONE;
            addra_q      <= '0;
            dina_q       <= '0;
            fill_count_q <= 8'd0;
        end else begin
            case (state)
                PW_IDLE: begin
                    if (bus.start) begin
                        idx          <= '0;
                        bank         <= '0;
                        prev_sym     <= SYM_NONE;
                        fill_count_q <= 8'd0;
                    end
                end
                PW_GEN: begin
                    if (cand_ok) begin
                        addra_q <= addr_calc;
                        dina_q  <= glyph_of(cand_sym);
                        sym_q   <= cand_sym;
                    end
                end
                PW_WRITE: begin
                    prev_sym     <= sym_q;
                    fill_count_q <= fill_count_q + 8'd1;
                    if (!last_idx) begin
                        idx <= idx + IDX_W'(1);
                    end else if (!last_bank) begin
                        idx  <= '0;
                        bank <= bank + BANK_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wea        = wr_pulse;
    assign bus.busy       = busy_flag;
    assign bus.done       = done_pulse;
    assign bus.addra      = addra_q;
    assign bus.dina       = dina_q;
    assign bus.fill_count = fill_count_q;

endmodule

// File: tb/tb_pattern_writer.sv
// tb_pattern_writer: drives several fills of pattern_writer and checks every
// write against a reference stream built straight from the symbol rules.
module tb_pattern_writer;

    localparam int TOTAL  = 200;
    localparam int DEPTH  = 50;
    localparam int BUDGET = 6000;

    localparam logic [27:0] G_UP   = 28'b1000001000110011111111111111;
    localparam logic [27:0] G_DOWN = 28'b1000000100000010101011001000;
    localparam logic [27:0] G_LEFT = 28'b1000111000011000011100000111;
    localparam logic [27:0] G_RITE = 28'b1001100111100100001110000110;
    localparam logic [27:0] G_MID  = 28'b1101010111100110000001111111;

    logic clk = 1'b0;
    logic rst;

    pattern_writer_if bus ();

    pattern_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    logic [27:0] exp_glyph [TOTAL];
    logic [7:0]  exp_addr  [TOTAL];
    logic [27:0] runs      [6][TOTAL];
    logic [7:0]  run_addr  [6][TOTAL];
    int          exp_ptr = 0;
    int          done_seen = 0;
    int          cur_run = 0;
    int          cyc = 0;
    int          last_wea_cyc = 0;
    logic [27:0] last_dina = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [27:0] glyph_for(input int sym);
        case (sym)
            0: return G_UP;
            1: return G_DOWN;
            2: return G_LEFT;
            3: return G_RITE;
            default: return G_MID;
        endcase
    endfunction

    function automatic bit is_glyph(input logic [27:0] g);
        return (g == G_UP) || (g == G_DOWN) || (g == G_LEFT) || (g == G_RITE) || (g == G_MID);
    endfunction

    // Reference stream: draw symbols from the LFSR, skipping codes 5..7 and
    // in-bank repeats, and lay them out at consecutive addresses
    function automatic void build_model(input logic [15:0] s);
        logic [15:0] l;
        int prev;
        int sym;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int b = 0; b < 4; b++) begin
            prev = -1;
            for (int i = 0; i < DEPTH; i++) begin
                do begin
                    l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                    sym = int'(l[2:0]);
                end while (sym > 4 || sym == prev);
                prev = sym;
                exp_addr[b * DEPTH + i]  = 8'(b * DEPTH + i);
                exp_glyph[b * DEPTH + i] = glyph_for(sym);
            end
        end
    endfunction

    // Compare every write and done pulse against the reference stream
    always @(negedge clk) begin
        cyc++;
        if (bus.wea === 1'b1) begin
            if (exp_ptr >= TOTAL) begin
                checkOutput("extra_write_count", 32'(exp_ptr), 32'(TOTAL - 1));
            end else begin
                checkOutput("addra", 32'(bus.addra), 32'(exp_addr[exp_ptr]));
                checkOutput("dina", 32'(bus.dina), 32'(exp_glyph[exp_ptr]));
                checkOutput("fill_count_at_write", 32'(bus.fill_count), 32'(exp_ptr));
                checkOutput("busy_at_write", 32'(bus.busy), 32'd1);
                checkOutput("dina_is_glyph", 32'(is_glyph(bus.dina)), 32'd1);
                if (exp_ptr % DEPTH != 0) begin
                    checkOutput("no_repeat_in_bank", 32'(bus.dina != last_dina), 32'd1);
                end
                if (exp_ptr != 0) begin
                    checkOutput("wea_gap_ge_2", 32'((cyc - last_wea_cyc) >= 2), 32'd1);
                end
                runs[cur_run][exp_ptr]     = bus.dina;
                run_addr[cur_run][exp_ptr] = bus.addra;
                exp_ptr++;
            end
            last_dina    = bus.dina;
            last_wea_cyc = cyc;
        end
        if (bus.done === 1'b1) begin
            done_seen++;
            checkOutput("writes_at_done", 32'(exp_ptr), 32'(TOTAL));
            checkOutput("busy_at_done", 32'(bus.busy), 32'd0);
            checkOutput("fill_count_at_done", 32'(bus.fill_count), 32'(TOTAL));
        end
    end

    // mode 0: plain fill, 1: re-pulse start at address 10, 2: reset after address 37
    task automatic applyStimulus(input int run_id, input bit do_load, input logic [15:0] s,
                                 input logic [15:0] model_seed, input int mode);
        bit got_done;
        bit aborted;
        int c;
        build_model(model_seed);
        cur_run   = run_id;
        exp_ptr   = 0;
        done_seen = 0;
        got_done  = 1'b0;
        aborted   = 1'b0;
        c         = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.seed_load = do_load;
        bus.seed      = s;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        while (!got_done && !aborted && c < BUDGET) begin
            @(negedge clk);
            c++;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
            end else if (mode == 1 && bus.wea === 1'b1 && bus.addra == 8'd10) begin
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
            end else if (mode == 2 && bus.wea === 1'b1 && bus.addra == 8'd37) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("abort_wea", 32'(bus.wea), 32'd0);
                checkOutput("abort_busy", 32'(bus.busy), 32'd0);
                checkOutput("abort_fill_count", 32'(bus.fill_count), 32'd0);
                checkOutput("abort_done", 32'(bus.done), 32'd0);
                repeat (5) @(negedge clk);
                checkOutput("abort_no_done", 32'(done_seen), 32'd0);
                checkOutput("abort_writes", 32'(exp_ptr), 32'd38);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            if (!got_done) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL done_timeout: no done within %0d cycles, writes seen %0d", BUDGET, exp_ptr);
            end
            repeat (3) @(negedge clk);
            checkOutput("done_pulses", 32'(done_seen), 32'd1);
            checkOutput("writes_total", 32'(exp_ptr), 32'(TOTAL));
            checkOutput("fill_count_idle", 32'(bus.fill_count), 32'(TOTAL));
            checkOutput("busy_idle", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int diffs;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        bus.seed      = 16'h0000;
        repeat (3) @(negedge clk);
        checkOutput("reset_wea", 32'(bus.wea), 32'd0);
        checkOutput("reset_addra", 32'(bus.addra), 32'd0);
        checkOutput("reset_dina", 32'(bus.dina), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_fill_count", 32'(bus.fill_count), 32'd0);
        rst = 1'b0;

        // Default seed straight out of reset; 0xACE1 shifts to 0x59C3 (RITE),
        // then 0xB387, 0x670F, 0xCE1E are rejected and 0x9C3C gives MID
        applyStimulus(0, 1'b0, 16'h0000, 16'hACE1, 0);
        checkOutput("model_entry0", 32'(exp_glyph[0]), 32'(G_RITE));
        checkOutput("model_entry1", 32'(exp_glyph[1]), 32'(G_MID));
        checkOutput("dut_entry0", 32'(runs[0][0]), 32'(G_RITE));
        checkOutput("dut_entry1", 32'(runs[0][1]), 32'(G_MID));
        checkOutput("dut_last_addr", 32'(run_addr[0][TOTAL - 1]), 32'd199);

        applyStimulus(1, 1'b1, 16'h1234, 16'h1234, 0);
        applyStimulus(2, 1'b1, 16'h1234, 16'h1234, 0);
        applyStimulus(3, 1'b1, 16'h1235, 16'h1235, 0);
        applyStimulus(4, 1'b1, 16'h0000, 16'hACE1, 0);

        diffs = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (runs[1][i] != runs[2][i] || run_addr[1][i] != run_addr[2][i]) diffs++;
        end
        checkOutput("same_seed_repeatable", 32'(diffs), 32'd0);
        diffs = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (runs[1][i] != runs[3][i]) diffs++;
        end
        checkOutput("other_seed_differs", 32'(diffs > 0), 32'd1);
        diffs = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (runs[0][i] != runs[4][i] || run_addr[0][i] != run_addr[4][i]) diffs++;
        end
        checkOutput("zero_seed_is_default", 32'(diffs), 32'd0);

        applyStimulus(5, 1'b1, 16'h5555, 16'h5555, 1);
        applyStimulus(5, 1'b1, 16'h00FF, 16'h00FF, 2);
        applyStimulus(5, 1'b0, 16'h0000, 16'hACE1, 0);
        checkOutput("restart_first_addr", 32'(run_addr[5][0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_writer.md
Name: pattern_writer

Overview:
- Fills the game's pattern block memory (4 banks x 50 entries of 28-bit seven-seg glyphs) with pseudo-random button symbols.
- It is the write side of the memory that gameplay reads back through wea=0 ports.
- Runs once per new game, triggered by the menu FSM, before gameplay begins its 50-cycle fetch.
- Drives the block_mem write port: wea, addra, dina.

Parameters:
- DEPTH, 50, entries per bank
- BANKS, 4, number of banks; bank b occupies addresses b*DEPTH .. b*DEPTH+DEPTH-1
- ADDR_W, 8, block memory address width
- DATA_W, 28, glyph width (4 digits x 7 segments, active-low)
- DEFAULT_SEED, 16'hACE1, LFSR value used on reset and when a zero seed is loaded
- NO_REPEAT, 1, when 1, the same symbol never appears twice consecutively within a bank

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to fill memory; ignored while busy
- seed_load  in  1  when high in IDLE, LFSR <= seed (or DEFAULT_SEED if seed==0)
- seed  in  16  seed value (e.g. free-running counter sampled at button press)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final write
- wea  out  1  block memory write enable
- addra  out  ADDR_W  write address
- dina  out  DATA_W  write data (glyph)
- fill_count  out  8  writes completed in the current or last fill

Behaviour:
- Reset values: wea=0, addra=0, dina=0, busy=0, done=0, fill_count=0, LFSR=DEFAULT_SEED, state=IDLE, prev_sym=NONE.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifted left.
  - New bit = l[15]^l[13]^l[12]^l[10].
  - Shifts once per GEN cycle only.
  - Never holds 0; a zero seed is replaced by DEFAULT_SEED.
- Symbol map, sym = l[2:0] after the shift:
  - 0 = UP, 1 = DOWN, 2 = LEFT, 3 = RITE, 4 = MID.
  - 5..7 are rejected: stay in GEN and shift again next cycle.
  - With NO_REPEAT=1, sym==prev_sym is also rejected.
  - prev_sym resets to NONE at each bank start (idx==0).
- Glyph constants, bit 27..0:
  - UP = 1000001000110011111111111111
  - DOWN = 1000000100000010101011001000
  - LEFT = 1000111000011000011100000111
  - RITE = 1001100111100100001110000110
  - MID = 1101010111100110000001111111
- FSM:
  - IDLE: seed_load is honoured here only. On start: bank=0, idx=0, fill_count=0, busy=1, go to GEN. If start and seed_load are high in the same cycle, the seed is loaded first and the fill uses the new seed.
  - GEN: shift LFSR. On an accepted symbol, latch dina=glyph, addra=bank*DEPTH+idx, go to WRITE. Otherwise stay in GEN.
  - WRITE: wea=1 for exactly this one cycle; prev_sym<=sym; fill_count+1. Then:
    - idx<DEPTH-1: idx+1, go to GEN.
    - else if bank<BANKS-1: idx=0, bank+1, go to GEN.
    - else: go to DONE.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- wea is low in every state except WRITE. addra and dina hold stable in the cycle wea is high and keep their last value afterwards.
- Address arithmetic uses ADDR_W bits. Max address BANKS*DEPTH-1 = 199 must be < 2^ADDR_W; this is checked at elaboration.
- Minimum fill time is 2 cycles per entry. Rejections add cycles, with no upper bound guaranteed; typical fill is ~640 cycles.
- start during busy is ignored; no queueing.
- rst mid-fill: next cycle is IDLE, wea=0, busy=0, done not pulsed. Memory contents already written are left as-is. fill_count resets to 0.
- Deterministic: the same seed produces an identical write stream.

Decomposition:
- Package game_pkg holds:
  - symbol enum (SYM_UP..SYM_MID, SYM_NONE)
  - the five glyph constants plus GOOD, LOSE and BLANK
  - DEPTH/BANKS defaults
  - These are shared with gameplay and the display path.
- Sub-module lfsr16 (enable, load, seed, value out) is separated for reuse by the menu's random-bank select.

Test Plan:
- Reset, then start with default seed -> exactly 200 wea pulses. addra = 0,1,...,199 in order. Every dina is one of the 5 glyphs. One done pulse after the 200th write. busy high throughout, fill_count=200.
- seed_load with seed=16'h1234 then start, run twice -> the two dina/addra sequences are bit-identical. A run with seed 16'h1235 differs in at least one entry.
- seed_load with seed=0 -> stream identical to the DEFAULT_SEED run.
- NO_REPEAT=1 -> no two consecutive writes within a bank have equal dina; entry 50 is allowed to equal entry 49. Cycles between wea pulses are always >=2.
- start re-pulsed at write 10 -> ignored: still 200 writes total, single done.
- rst asserted the cycle after write 37 -> next cycle wea=0, busy=0, fill_count=0, no done. A subsequent start begins again at addra=0.
